// File: rtl/easyaxi_pkg.sv
// Shared widths, response codes and state encoding for the easyaxi read slave.
package easyaxi_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;
    localparam int OST_DEPTH      = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rdState_e;

endpackage

// File: rtl/easyaxi_fifo.sv
// Small synchronous FIFO holding outstanding read requests.
// The head entry is visible on dout_o while the FIFO is not empty.
module easyaxi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rdPtr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// AXI read slave engine: queues AR requests and returns INCR bursts in order,
// with each beat's data equal to that beat's byte address.
module easyaxi_slv_rd
    import easyaxi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_WIDTH,
    parameter int ADDR_W = AXI_ADDR_WIDTH,
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int LEN_W  = AXI_LEN_WIDTH,
    parameter int DEPTH  = OST_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              axi_slv_arvalid,
    output logic              axi_slv_arready,
    input  logic [ID_W-1:0]   axi_slv_arid,
    input  logic [ADDR_W-1:0] axi_slv_araddr,
    input  logic [LEN_W-1:0]  axi_slv_arlen,
    output logic              axi_slv_rvalid,
    input  logic              axi_slv_rready,
    output logic [ID_W-1:0]   axi_slv_rid,
    output logic [DATA_W-1:0] axi_slv_rdata,
    output logic [1:0]        axi_slv_rresp,
    output logic              axi_slv_rlast
);

    localparam int CNT_W      = $clog2(DEPTH) + 1;
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int REQ_W      = ID_W + ADDR_W + LEN_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } arReq_t;

    arReq_t            pushReq;
    arReq_t            headReq;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;

    rdState_e          state_q, state_d;
    logic              rvalid_q;
    logic              rlast_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] curAddr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic              rHandshake;
    logic              loadBeat;
    logic              stepBeat;
    logic              endBurst;

    // rst_n gates arready directly so no request can be taken while reset is held.
    assign axi_slv_arready = rst_n && enable && (fifoCount != CNT_W'(DEPTH));
    assign fifoPush        = axi_slv_arvalid && axi_slv_arready && !fifoFull;
    assign pushReq         = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen};

    easyaxi_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_arFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifoPush),
        .din_i   (pushReq),
        .pop_i   (fifoPop),
        .dout_o  (headReq),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign rHandshake = rvalid_q && axi_slv_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (!fifoEmpty) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (rHandshake && rlast_q && fifoEmpty) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Chaining the next pop onto the last handshake avoids a bubble between bursts.
    always_comb begin
        fifoPop  = 1'b0;
        loadBeat = 1'b0;
        stepBeat = 1'b0;
        endBurst = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop  = 1'b1;
                    loadBeat = 1'b1;
                end
            end
            RD_BURST: begin
                if (rHandshake) begin
                    if (!rlast_q) begin
                        stepBeat = 1'b1;
                    end else if (!fifoEmpty) begin
                        fifoPop  = 1'b1;
                        loadBeat = 1'b1;
                    end else begin
                        endBurst = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            id_q      <= '0;
            curAddr_q <= '0;
            len_q     <= '0;
            beat_q    <= '0;
        end else if (loadBeat) begin
            rvalid_q  <= 1'b1;
            rlast_q   <= (headReq.len == '0);
            id_q      <= headReq.id;
            curAddr_q <= headReq.addr;
            len_q     <= headReq.len;
            beat_q    <= '0;
        end else if (stepBeat) begin
            rlast_q   <= ((beat_q + LEN_W'(1)) == len_q);
            curAddr_q <= curAddr_q + ADDR_W'(BEAT_BYTES);
            beat_q    <= beat_q + LEN_W'(1);
        end else if (endBurst) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end
    end

    assign axi_slv_rvalid = rvalid_q;
    assign axi_slv_rlast  = rlast_q;
    assign axi_slv_rid    = id_q;
    assign axi_slv_rdata  = DATA_W'(curAddr_q);
    assign axi_slv_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Randomized and directed bench for easyaxi_slv_rd against a queue-based
// model of outstanding requests and the burst currently being returned.
module tb_easyaxi_slv_rd;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        int          len;
    } req_t;

    req_t        mq[$];
    bit          mBusy = 0;
    logic [3:0]  mId;
    logic [31:0] mBase;
    int          mLen;
    int          mBeat;
    bit          lastAcc;

    easyaxi_slv_rd dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStart();
        req_t r;
        r = mq.pop_front();
        mId   = r.id;
        mBase = r.addr;
        mLen  = r.len;
        mBeat = 0;
        mBusy = 1;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
    task automatic applyStimulus(input logic arv, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic rr, input logic en);
        logic [31:0] expData;
        bit          expArready;
        bit          acc;
        bit          rhs;
        @(negedge clk);
        arvalid = arv;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        rready  = rr;
        enable  = en;
        #1;
        expArready = en && (mq.size() != DEPTH);
        checkOutput("arready", arready, expArready);
        checkOutput("rvalid", rvalid, mBusy);
        checkOutput("rresp", rresp, 2'b00);
        if (mBusy) begin
            expData = mBase + 32'(mBeat * 4);
            checkOutput("rid", rid, mId);
            checkOutput("rdata", rdata, expData);
            checkOutput("rlast", rlast, mBeat == mLen);
        end
        acc     = arv && expArready;
        rhs     = mBusy && rr;
        lastAcc = acc;
        @(posedge clk);
        if (!mBusy) begin
            if (mq.size() > 0) modelStart();
        end else if (rhs) begin
            if (mBeat == mLen) begin
                if (mq.size() > 0) modelStart();
                else mBusy = 0;
            end else begin
                mBeat++;
            end
        end
        if (acc) mq.push_back('{id: id, addr: addr, len: int'(len)});
    endtask

    task automatic sendAr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic rr);
        int n = 0;
        lastAcc = 0;
        while (!lastAcc && n < 60) begin
            applyStimulus(1'b1, id, addr, len, rr, 1'b1);
            n++;
        end
        checkOutput("arAccept", lastAcc, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((mBusy || mq.size() != 0) && n < 400) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 8'h0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("drainDone", (mBusy || mq.size() != 0), 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n   = 1'b0;
        arvalid = 1'b0;
        #1;
        checkOutput("rstRvalid", rvalid, 1'b0);
        checkOutput("rstArready", arready, 1'b0);
        checkOutput("rstRlast", rlast, 1'b0);
        checkOutput("rstRid", rid, 4'h0);
        checkOutput("rstRdata", rdata, 32'h0);
        mq.delete();
        mBusy = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        doReset();

        // Single beat: first rvalid two cycles after the AR handshake.
        sendAr(4'd3, 32'h0000_1000, 8'd0, 1'b1);
        drain();

        // Four-beat burst with a two-cycle stall on beat 1.
        sendAr(4'd1, 32'h0000_0020, 8'd3, 1'b1);
        for (int n = 0; n < 20 && !(mBusy && mBeat == 1); n++)
            applyStimulus(1'b0, 4'h0, 32'h0, 8'h0, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 4'h0, 32'h0, 8'h0, 1'b0, 1'b1);
        drain();

        // Fill the queue while R is blocked, then confirm further AR is refused.
        for (int i = 0; i < 5; i++)
            sendAr(4'(i), 32'h0000_4000 + 32'(i * 32'h100), 8'd1, 1'b0);
        repeat (3) applyStimulus(1'b1, 4'd7, 32'h0000_5000, 8'd0, 1'b0, 1'b1);
        drain();

        // Enable gating with a burst in flight.
        sendAr(4'd6, 32'h0000_0300, 8'd5, 1'b1);
        repeat (4) applyStimulus(1'b1, 4'd2, 32'h0000_0400, 8'd0, 1'b1, 1'b0);
        sendAr(4'd2, 32'h0000_0400, 8'd0, 1'b1);
        drain();

        // Address wrap at the top of the address space.
        sendAr(4'd9, 32'hFFFF_FFFC, 8'd1, 1'b1);
        drain();

        // Reset during beat 2 of a long burst with two more requests queued.
        sendAr(4'd0, 32'h0000_0100, 8'd7, 1'b0);
        sendAr(4'd1, 32'h0000_0200, 8'd3, 1'b0);
        sendAr(4'd2, 32'h0000_0300, 8'd2, 1'b0);
        for (int n = 0; n < 20 && !(mBusy && mBeat == 2); n++)
            applyStimulus(1'b0, 4'h0, 32'h0, 8'h0, 1'b1, 1'b1);
        doReset();
        repeat (6) applyStimulus(1'b0, 4'h0, 32'h0, 8'h0, 1'b1, 1'b1);
        sendAr(4'd5, 32'h0000_0800, 8'd2, 1'b1);
        drain();

        // Randomized traffic, with one reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] len;
            if (c == 750) doReset();
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom), len,
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
